// File: rtl/cpu_pkg.sv
// cpu_pkg: shared loader state encoding, error codes and default widths
package cpu_pkg;
  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 8;
  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_CHECK, ST_DONE, ST_ERR} state_t;
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_SUM  = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;
endpackage

// File: rtl/loader_timeout.sv
// loader_timeout: idle-cycle counter that flags expiry on the TIMEOUT-th consecutive idle cycle
module loader_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= (clr || !en) ? '0 : cnt + CW'(1);
  assign expired = en && !clr && (cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/prog_loader.sv
// prog_loader: streams a length-prefixed, checksummed program into memory while holding the CPU in reset
module prog_loader
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [5:0]        load_len,
  input  logic              byte_valid,
  input  logic [DATA_W-1:0] byte_data,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wr,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);
  state_t state;
  logic [5:0] cnt, len;
  logic [DATA_W-1:0] sum;
  logic xfer, expired;
  assign busy = (state == ST_LOAD) || (state == ST_CHECK);
  assign byte_ready = busy;
  assign xfer = byte_valid && byte_ready;
  loader_timeout #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk(clk), .rst(rst), .en(busy), .clr(xfer), .expired(expired)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_IDLE;
      cnt <= '0;
      len <= '0;
      sum <= '0;
      mem_addr <= '0;
      mem_data <= '0;
      mem_wr <= 1'b0;
      cpu_rst <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      mem_wr <= 1'b0;
      case (state)
        ST_LOAD:
          if (xfer) begin
            mem_addr <= cnt[ADDR_W-1:0];
            mem_data <= byte_data;
            mem_wr <= 1'b1;
            sum <= sum + byte_data;
            cnt <= cnt + 6'd1;
            if (cnt + 6'd1 == len) state <= ST_CHECK;
          end else if (expired) begin
            state <= ST_ERR;
            err <= 1'b1;
            err_code <= ERR_TMO;
          end
        ST_CHECK:
          if (xfer) begin
            if (DATA_W'(sum + byte_data) == '0) begin
              state <= ST_DONE;
              done <= 1'b1;
              cpu_rst <= 1'b0;
            end else begin
              state <= ST_ERR;
              err <= 1'b1;
              err_code <= ERR_SUM;
            end
          end else if (expired) begin
            state <= ST_ERR;
            err <= 1'b1;
            err_code <= ERR_TMO;
          end
        default:
          if (start) begin
            done <= 1'b0;
            cpu_rst <= 1'b1;
            if (load_len != 6'd0 && load_len <= 6'd32) begin
              state <= ST_LOAD;
              cnt <= '0;
              sum <= '0;
              len <= load_len;
              err <= 1'b0;
              err_code <= ERR_NONE;
            end else begin
              state <= ST_ERR;
              err <= 1'b1;
              err_code <= ERR_LEN;
            end
          end
      endcase
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: scoreboard bench with random loads checked against a per-load arithmetic model
module tb_prog_loader;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, byte_valid = 1'b0;
  logic [5:0] load_len = '0;
  logic [7:0] byte_data = '0;
  logic byte_ready, mem_wr, cpu_rst, busy, done, err;
  logic [4:0] mem_addr;
  logic [7:0] mem_data;
  logic [1:0] err_code;
  int total = 0, bad = 0, run = 0, max_run = 0;
  logic [12:0] exp_q[$];
  logic [7:0] pb[32];
  prog_loader dut (
    .clk(clk), .rst(rst), .start(start), .load_len(load_len),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wr(mem_wr),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err), .err_code(err_code)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    run = (!rst && mem_wr) ? run + 1 : 0;
    if (run > max_run) max_run = run;
    if (!rst && mem_wr) begin
      if (exp_q.size() == 0) chk("unexpected_mem_wr", {mem_addr, mem_data}, -1);
      else chk("mem_write", {mem_addr, mem_data}, exp_q.pop_front());
    end
  end
  task automatic do_start(input int len);
    start = 1'b1;
    load_len = 6'(len);
    @(posedge clk); #1;
    start = 1'b0;
  endtask
  task automatic send(input logic [7:0] b, input int gap);
    int n = 0;
    byte_valid = 1'b1;
    byte_data = b;
    @(negedge clk);
    while (!byte_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!byte_ready) chk("byte_ready_wait", byte_ready, 1);
    @(posedge clk); #1;
    if (gap > 0) begin
      byte_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask
  task automatic run_load(input int len, input logic [7:0] ck, input int gmax);
    int s = 0;
    do_start(len);
    for (int i = 0; i < len; i++) begin
      exp_q.push_back({5'(i), pb[i]});
      s += pb[i];
      send(pb[i], int'($urandom_range(gmax, 0)));
    end
    send(ck, 1);
    @(negedge clk);
    if ((s + ck) % 256 == 0) begin
      chk("done", done, 1);
      chk("err_clear", err, 0);
      chk("cpu_rst_done", cpu_rst, 0);
    end else begin
      chk("err_sum", err, 1);
      chk("err_code_sum", err_code, 2);
      chk("cpu_rst_err", cpu_rst, 1);
    end
    chk("busy_end", busy, 0);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", {byte_ready, mem_wr, cpu_rst, busy, done, err, err_code, mem_addr, mem_data}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    pb[0] = 8'h21; pb[1] = 8'h42; pb[2] = 8'h10;
    run_load(3, 8'h8D, 2);
    run_load(3, 8'h00, 2);
    do_start(0);
    @(negedge clk);
    chk("len0_code", err_code, 1);
    chk("len0_ready", byte_ready, 0);
    do_start(33);
    @(negedge clk);
    chk("len33_err", err, 1);
    chk("len33_code", err_code, 1);
    chk("len33_ready", byte_ready, 0);
    repeat (3) @(posedge clk);
    #1;
    do_start(2);
    exp_q.push_back({5'd0, 8'h55});
    send(8'h55, 1);
    repeat (248) @(negedge clk);
    chk("tmo_not_yet", busy, 1);
    repeat (12) @(negedge clk);
    chk("tmo_err", err, 1);
    chk("tmo_code", err_code, 3);
    chk("tmo_busy", busy, 0);
    pb[0] = 8'h01; pb[1] = 8'h02; pb[2] = 8'h03;
    do_start(3);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({5'(i), pb[i]});
      send(pb[i], 200 + 25 * i);
    end
    send(8'hFA, 1);
    @(negedge clk);
    chk("gap_done", done, 1);
    chk("gap_no_err", err, 0);
    for (int i = 0; i < 32; i++) pb[i] = 8'(i);
    max_run = 0;
    run_load(32, 8'h10, 0);
    chk("run32", max_run, 32);
    for (int t = 0; t < 8; t++) begin
      int len, s;
      logic [7:0] ck;
      len = int'($urandom_range(32, 1));
      s = 0;
      for (int i = 0; i < len; i++) begin
        pb[i] = 8'($urandom);
        s += pb[i];
      end
      ck = ($urandom_range(3, 0) != 0) ? 8'(256 - s % 256) : 8'($urandom);
      run_load(len, ck, 3);
    end
    pb[0] = 8'hA5; pb[1] = 8'h5A;
    do_start(4);
    exp_q.push_back({5'd0, pb[0]});
    exp_q.push_back({5'd1, pb[1]});
    send(pb[0], 0);
    send(pb[1], 1);
    byte_valid = 1'b1;
    byte_data = 8'h77;
    rst = 1'b1;
    #1;
    chk("rst_mid_outputs", {byte_ready, mem_wr, cpu_rst, busy, done, err, err_code, mem_addr, mem_data}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_idle_busy", busy, 0);
    chk("rst_idle_cpu_rst", cpu_rst, 0);
    byte_valid = 1'b0;
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ADDR_W, default 5, memory address width.
REQ-002 Parameter DATA_W, default 8, memory/byte data width.
REQ-003 Parameter TIMEOUT, default 255, max idle cycles between bytes while loading.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to begin a load.
REQ-007 load_len  input  6  number of program bytes, legal range 1..32, sampled on start.
REQ-008 byte_valid  input  1  upstream byte present.
REQ-009 byte_data  input  8  upstream byte.
REQ-010 byte_ready  output  1  loader accepts byte this cycle.
REQ-011 mem_addr  output  5  memory write address.
REQ-012 mem_data  output  8  memory write data.
REQ-013 mem_wr  output  1  one-cycle memory write strobe.
REQ-014 cpu_rst  output  1  holds CPU in reset while high.
REQ-015 busy  output  1  load in progress.
REQ-016 done  output  1  load completed with good checksum, sticky.
REQ-017 err  output  1  load aborted, sticky.
REQ-018 err_code  output  2  01 bad length, 10 checksum mismatch, 11 timeout, 00 none.

Function
REQ-019 Transfer occurs on any cycle with byte_valid and byte_ready both high; at most one byte per cycle.
REQ-020 States: IDLE, LOAD, CHECK, DONE, ERR.
REQ-021 IDLE/DONE/ERR + start: load_len 1..32 -> LOAD, byte counter=0, checksum=0, done/err/err_code cleared; else -> ERR, err_code=01.
REQ-022 start in LOAD or CHECK is ignored.
REQ-023 LOAD: byte_ready=1; each transfer registers mem_addr=counter, mem_data=byte_data, pulses mem_wr one cycle later for exactly one cycle, adds byte to checksum mod 256, increments counter.
REQ-024 LOAD -> CHECK on transfer of byte number load_len (counter reaching load_len).
REQ-025 CHECK: byte_ready=1; next transfer is the checksum byte, never written to memory; (checksum + byte) mod 256 == 0 -> DONE, else ERR with err_code=10.
REQ-026 Idle counter resets on every transfer and on entry to LOAD; reaching TIMEOUT cycles without a transfer in LOAD or CHECK -> ERR, err_code=11.
REQ-027 Timeout and transfer in the same cycle: the transfer wins, counter resets.
REQ-028 busy=1 exactly in LOAD and CHECK; byte_ready=0 in IDLE, DONE, ERR.
REQ-029 cpu_rst=1 from the cycle after an accepted start through LOAD, CHECK and ERR; cpu_rst=0 in IDLE and DONE.
REQ-030 The final mem_wr pulse of a load completes before or in the same cycle as the DONE/ERR transition.
REQ-031 Address never wraps: counter is 6 bits, load_len<=32 bounds mem_addr to 0..31.

Reset
REQ-032 rst forces IDLE asynchronously; counters, checksum, mem_addr, mem_data cleared to 0.
REQ-033 Reset values: byte_ready=0, mem_wr=0, cpu_rst=0, busy=0, done=0, err=0, err_code=00.
REQ-034 rst during LOAD abandons the load; no further mem_wr issued after rst asserts.

Structure
REQ-035 State encoding, err_code constants and ADDR_W/DATA_W defaults live in a shared package cpu_pkg.
REQ-036 One sub-module, loader_timeout (idle counter with clear and expire flag), is instantiated once.
REQ-037 Outputs mem_addr, mem_data, mem_wr, cpu_rst are registered.

Verification
REQ-038 start, load_len=3, bytes 0x21,0x42,0x10 then 0x8D -> writes addr0=0x21, addr1=0x42, addr2=0x10; done=1, cpu_rst=0.
REQ-039 Same load with checksum byte 0x00 -> three writes occur, err=1, err_code=10, cpu_rst stays 1.
REQ-040 start with load_len=0 and then load_len=33 -> ERR, err_code=01, no mem_wr, byte_ready=0.
REQ-041 load_len=2, one byte sent then byte_valid low 255 cycles -> err_code=11; byte_valid toggled with gaps <255 -> no timeout.
REQ-042 load_len=32, back-to-back bytes 0x00..0x1F plus checksum 0x10 -> 32 consecutive writes addr 0..31, done=1.
REQ-043 rst asserted after 2 of 4 bytes -> IDLE next edge, all outputs at reset values, no further writes.
